reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 85 ++++++++
 tb/tb_reg_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-write scoreboard for an in-order decode stage.
// Tracks one pending-write bit per architectural register (X31 = XZR, never
// pending) and raises a combinational stall on RAW/WAW hazards.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   issue_valid         decode presents an instruction
//   issue_rd/src_a/src_b destination and source register numbers
//   rd_used/src_b_used  instruction writes rd / reads src_b
//   wb_valid, wb_rd     writeback retires a register write
//   flush               discard all in-flight writers
//   stall               combinational hazard indication
//   busy_mask           registered pending-write bit per register
//   pending_count       registered popcount of busy_mask
//
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to let a same-cycle
// writeback hide its register from the stall check (value forwarded).
module reg_scoreboard (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic        rd_used,
  input  logic        src_b_used,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] busy_mask,
  output logic [5:0]  pending_count
);

  localparam logic [4:0] XZR = 5'd31;

  logic [31:0] busy_q, busy_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] pend;
  logic        accept;

  // Effective pending view used for hazard detection.
  always_comb begin
    pend = busy_q;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid) pend[wb_rd] = 1'b0;
`endif
    pend[XZR] = 1'b0;
  end

  assign stall = issue_valid &
                 (pend[src_a] | (src_b_used & pend[src_b]) | (rd_used & pend[issue_rd]));

  assign accept = issue_valid & ~stall & ~flush;

  // Clear first, then set, so a same-cycle issue to the written-back register
  // leaves it pending. Flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && wb_rd != XZR) busy_d[wb_rd] = 1'b0;
    if (accept && rd_used && issue_rd != XZR) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[XZR] = 1'b0;
  end

  // Count the next mask so pending_count is registered alongside busy_mask.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < 32; i++) cnt_d = cnt_d + 6'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_mask     = busy_q;
  assign pending_count = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = 5'd31, src_a = 5'd31, src_b = 5'd31;
  logic        rd_used = 1'b0, src_b_used = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd31;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] busy_mask;
  logic [5:0]  pending_count;

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .src_a(src_a), .src_b(src_b), .rd_used(rd_used), .src_b_used(src_b_used),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall),
    .busy_mask(busy_mask), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  // Reference model: set of registers with an outstanding writer.
  bit mdl [32];

  function automatic bit m_pend(int r);
    bit p;
    p = mdl[r] && (r != 31);
    if (BYP && wb_valid && int'(wb_rd) == r) p = 1'b0;
    return p;
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_pend(src_a) || (src_b_used && m_pend(src_b)) ||
                           (rd_used && m_pend(issue_rd)));
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = mdl[i];
    return m;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mdl[i]);
    return c;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 1'b0;
    end else begin
      bit acc;
      acc = issue_valid && !m_stall() && !flush;
      if (flush) begin
        for (int i = 0; i < 32; i++) mdl[i] = 1'b0;
      end else begin
        if (wb_valid && wb_rd != 5'd31) mdl[wb_rd] = 1'b0;
        if (acc && rd_used && issue_rd != 5'd31) mdl[issue_rd] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_chk && reset_n) begin
      chk("cyc_stall", {31'd0, stall}, {31'd0, m_stall()});
      chk("cyc_mask", busy_mask, m_mask());
      chk("cyc_count", {26'd0, pending_count}, 32'(m_count()));
    end
  end

  task automatic drive(input bit iv, input int rd, input int a, input int b,
                       input bit ru, input bit bu, input bit wv, input int wr, input bit fl);
    @(posedge clk); #1;
    issue_valid = iv; issue_rd = 5'(rd); src_a = 5'(a); src_b = 5'(b);
    rd_used = ru; src_b_used = bu; wb_valid = wv; wb_rd = 5'(wr); flush = fl;
  endtask

  task automatic idle();
    drive(0, 31, 31, 31, 0, 0, 0, 31, 0);
  endtask

  task automatic issue_rd_only(input int rd);
    drive(1, rd, 31, 31, 1, 0, 0, 31, 0);
  endtask

  initial begin
    #12;
    chk("reset_mask", busy_mask, 32'h0);
    chk("reset_count", {26'd0, pending_count}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    run_chk = 1'b1;

    // Issue rd=5 then a reader of X5.
    issue_rd_only(5);
    drive(1, 31, 5, 31, 0, 0, 0, 31, 0); #2;
    chk("r27_mask", busy_mask, 32'h0000_0020);
    chk("r27_count", {26'd0, pending_count}, 32'd1);
    chk("r27_stall", {31'd0, stall}, 32'd1);

    // Writeback of X5 with a same-cycle src_b reader.
    drive(1, 31, 31, 5, 0, 1, 1, 5, 0); #2;
    chk("r28_stall", {31'd0, stall}, BYP ? 32'd0 : 32'd1);
    idle(); #2;
    chk("r28_mask", busy_mask, 32'h0);

    // XZR never becomes pending.
    for (int k = 0; k < 4; k++) begin
      drive(1, 31, 31, 31, 1, 0, 0, 31, 0); #2;
      chk("r29_stall", {31'd0, stall}, 32'd0);
      chk("r29_mask", busy_mask, 32'h0);
    end

    // WAW on X7, then set-wins on X9.
    issue_rd_only(7);
    drive(1, 7, 31, 31, 1, 0, 0, 31, 0); #2;
    chk("r30_waw", {31'd0, stall}, 32'd1);
    issue_rd_only(9);
    drive(0, 31, 31, 31, 0, 0, 1, 9, 0); #2;
    chk("r30_mask79", busy_mask, 32'h0000_0280);
    drive(1, 9, 31, 31, 1, 0, 1, 9, 0); #2;
    chk("r30_clr9", busy_mask, 32'h0000_0080);
    idle(); #2;
    chk("r30_setwins", busy_mask, 32'h0000_0280);

    // Fill 1..30, then flush with an issue.
    drive(0, 31, 31, 31, 0, 0, 0, 31, 1);
    for (int r = 1; r <= 30; r++) issue_rd_only(r);
    drive(1, 0, 31, 31, 1, 0, 0, 31, 1); #2;
    chk("r31_count", {26'd0, pending_count}, 32'd30);
    chk("r31_mask", busy_mask, 32'h7FFF_FFFE);
    idle(); #2;
    chk("r31_flush_mask", busy_mask, 32'h0);
    chk("r31_flush_cnt", {26'd0, pending_count}, 32'd0);

    // Asynchronous reset pulse between edges.
    issue_rd_only(3);
    issue_rd_only(4);
    idle();
    #1 reset_n = 1'b0;
    #1;
    chk("r32_mask", busy_mask, 32'h0);
    chk("r32_count", {26'd0, pending_count}, 32'd0);
    #1 reset_n = 1'b1;
    drive(1, 31, 3, 31, 0, 0, 0, 31, 0); #2;
    chk("r32_stall", {31'd0, stall}, 32'd0);

    // Randomised traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      int lim;
      lim = ($urandom_range(0, 7) == 0) ? 31 : 7;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, lim), $urandom_range(0, lim),
            $urandom_range(0, lim), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, lim), $urandom_range(0, 40) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end
    idle();
    @(posedge clk);
    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
